dac_tx: RTL

//  Playback-direction counterpart of the scope's ADC capture path: buffers 12-bit samples in a FIFO and

---
 rtl/dac_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dac_tx.sv
// Sample FIFO feeding a 16-bit serial DAC frame (4 config bits + 12 data bits)
// with a tick-divided SCLK and a one-tick LDAC strobe after each frame.
module dac_tx #(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [3:0]  CFG_BITS   = 4'b0111
) (
  input  logic                          osc_clk,
  input  logic                          reset,
  input  logic [11:0]                   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          enable,
  input  logic                          clr_underrun,
  output logic                          dac_cs_n,
  output logic                          dac_sclk,
  output logic                          dac_sdi,
  output logic                          dac_ldac_n,
  output logic                          busy,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT_H, S_SHIFT_L, S_END, S_LATCH
  } state_t;

  // tick divider
  logic [CW-1:0] cnt;
  logic          tick;
  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // sample FIFO
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          push, pop;

  assign in_ready   = (level != (AW+1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_level = level;

  always_ff @(posedge osc_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // frame FSM: each state's actions are registered on its tick
  state_t      state, state_d;
  logic [15:0] shreg, shreg_d;
  logic [3:0]  bit_idx, bit_d, bit_m1;
  logic        cs_d, sclk_d, sdi_d, ldac_d, set_ur;

  assign bit_m1 = bit_idx - 4'd1;
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bit_d   = bit_idx;
    cs_d    = dac_cs_n;
    sclk_d  = dac_sclk;
    sdi_d   = dac_sdi;
    ldac_d  = dac_ldac_n;
    pop     = 1'b0;
    set_ur  = 1'b0;
    if (tick) begin
      ldac_d = 1'b1;
      unique case (state)
        S_IDLE: begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          if (enable && level != '0) begin
            pop     = 1'b1;
            shreg_d = {CFG_BITS, mem[rd_ptr]};
            bit_d   = 4'd15;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          sdi_d   = shreg[15];
          state_d = S_SHIFT_H;
        end
        S_SHIFT_H: begin
          sclk_d  = 1'b1;
          state_d = S_SHIFT_L;
        end
        // the last bit also gets its low half, so SCLK is low before CS rises
        S_SHIFT_L: begin
          sclk_d = 1'b0;
          if (bit_idx == 4'd0) begin
            state_d = S_END;
          end else begin
            bit_d   = bit_m1;
            sdi_d   = shreg[bit_m1];
            state_d = S_SHIFT_H;
          end
        end
        S_END: begin
          sclk_d  = 1'b0;
          cs_d    = 1'b1;
          state_d = S_LATCH;
        end
        S_LATCH: begin
          ldac_d  = 1'b0;
          set_ur  = enable && (level == '0);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ldac_n <= 1'b1;
      underrun   <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_idx    <= bit_d;
      dac_cs_n   <= cs_d;
      dac_sclk   <= sclk_d;
      dac_sdi    <= sdi_d;
      dac_ldac_n <= ldac_d;
      if (clr_underrun) underrun <= 1'b0;
      else if (set_ur)  underrun <= 1'b1;
    end
  end

endmodule
